mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Memory-access stage of the pipeline. It sits between the EXE/MEM pipeline register and the MEM/WB pipeline register.
- Performs loads and stores against a 32-bit data-memory bus that uses a req/ack handshake.
- Supports 32-bit word accesses and 64-bit doubleword accesses (FP ldc1/sdc1). A doubleword access runs as two bus beats.
- Drives MEM_Result, MEM_R_memtoReg and MEM_memWrite into MEM/WB, and stalls the pipeline while a bus transaction is in flight.

Parameters:
TIMEOUT_CYCLES, 16, number of consecutive cycles req may stay high without ack before the access is aborted (range 2..255)

Ports:
clk  in  1  pipeline clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
EXE_MEM_MemRead  in  1  current instruction is a load
EXE_MEM_MemWrite  in  1  current instruction is a store
EXE_MEM_Double  in  1  1 = 64-bit access, 0 = 32-bit word access
EXE_MEM_Result  in  64  ALU result; bits [31:0] are the byte address
EXE_MEM_StoreData  in  64  store data; for word stores only [31:0] is used
dmem_req  out  1  bus request
dmem_we  out  1  1 = write beat, 0 = read beat
dmem_addr  out  32  bus word address (byte address, 4-aligned)
dmem_wdata  out  32  write data
dmem_rdata  in  32  read data, valid when dmem_ack=1
dmem_ack  in  1  beat complete
MEM_Result  out  64  load result to MEM/WB
MEM_R_memtoReg  out  1  load completed this cycle
MEM_memWrite  out  1  store completed this cycle
MEM_Stall  out  1  hold PC, IF/ID, ID/EXE and EXE/MEM; MEM/WB must not capture
MEM_Misaligned  out  1  alignment exception pulse
MEM_BusError  out  1  timeout abort pulse

Behaviour:
- Reset values:
  - State IDLE.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - MEM_Result=0, MEM_R_memtoReg=0, MEM_memWrite=0.
  - MEM_Misaligned=0, MEM_BusError=0, timeout counter=0.
  - MEM_Stall=0 while rst=1.
- memop = EXE_MEM_MemRead | EXE_MEM_MemWrite. If both are 1, treat as a load.
- Alignment:
  - A word access is aligned iff addr[1:0]=0.
  - A doubleword access is aligned iff addr[2:0]=0.
- FSM states: IDLE, BEAT_LO, BEAT_HI, DONE.
- IDLE:
  - No memop: MEM_Stall=0, no bus activity, MEM_R_memtoReg=0, MEM_memWrite=0.
  - Misaligned memop: MEM_Misaligned=1 combinationally for that cycle, MEM_Stall=0, no request, stay in IDLE.
  - Aligned memop: MEM_Stall=1 combinationally. Next edge goes to BEAT_LO with dmem_req=1, dmem_addr=addr, dmem_we=store, dmem_wdata=StoreData[31:0].
- BEAT_LO and BEAT_HI:
  - MEM_Stall=1.
  - dmem_req, dmem_addr, dmem_we and dmem_wdata are registered and held stable until dmem_ack is sampled 1.
- BEAT_LO on ack:
  - Loads capture dmem_rdata into the low word.
  - Word access: go to DONE, dmem_req=0.
  - Double access: go to BEAT_HI with dmem_addr=addr+4 and dmem_wdata=StoreData[63:32]. req stays 1, so there is no idle bus cycle between beats.
- BEAT_HI on ack: loads capture the high word; go to DONE with dmem_req=0.
- DONE (exactly one cycle):
  - MEM_Stall=0.
  - For loads, MEM_R_memtoReg=1. MEM_Result = {hi,lo} for a double, or sign-extended lo[31] for a word.
  - For stores, MEM_memWrite=1 and MEM_Result is unchanged.
  - MEM/WB captures at the closing edge. Next state is IDLE.
- MEM_Result holds its value outside DONE. MEM_R_memtoReg and MEM_memWrite are 1-cycle pulses.
- Latency with ack in the first req cycle, from instruction arrival to the MEM/WB capture edge:
  - Word: 3 cycles.
  - Double: 4 cycles.
- Each wait cycle without ack adds one cycle.
- Timeout:
  - The counter increments each cycle with req=1 and ack=0, and clears on ack or on entering IDLE.
  - When it reaches TIMEOUT_CYCLES, drop req and go to DONE with MEM_BusError=1, MEM_Result=0, MEM_R_memtoReg=0, MEM_memWrite=0.
  - MEM_BusError is a 1-cycle pulse.
- dmem_ack while dmem_req=0 (IDLE or DONE) is ignored.
- Reset mid-access: at the first edge with rst=1 the FSM goes to IDLE, req drops, and captured data is discarded. A late ack after reset is ignored.
- EXE_MEM_* inputs must be stable while MEM_Stall=1. The block does not re-sample them after leaving IDLE.

Test Plan:
- Word load, addr=0x100, rdata=0x8000_0001, ack in first req cycle -> req high for exactly 1 cycle; DONE at cycle 2 with MEM_Result=0xFFFF_FFFF_8000_0001 and MEM_R_memtoReg=1; MEM_Stall high for cycles 0–1 only.
- Double store, addr=0x208, data=0x1122_3344_5566_7788, ack after 2 wait cycles per beat -> beat 1 addr=0x208, wdata=0x5566_7788; beat 2 addr=0x20C, wdata=0x1122_3344; MEM_memWrite pulses once; total stall 7 cycles.
- Misaligned word load, addr=0x102 -> MEM_Misaligned=1 for 1 cycle, MEM_Stall=0, dmem_req never asserts.
- Double load with ack never returned, TIMEOUT_CYCLES=4 -> req high for 4 cycles, then MEM_BusError pulse, MEM_Result=0, FSM back in IDLE.
- rst asserted during BEAT_HI of a double load, then ack arrives 1 cycle after reset -> req=0 the cycle after the reset edge; no MEM_R_memtoReg pulse; MEM_Result=0.
- Non-memory op (MemRead=MemWrite=0) and back-to-back word loads -> no stall for the ALU op; the second load issues req the cycle after the first load's DONE.

Source files
------------

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access stage of the pipeline, between the EXE/MEM and MEM/WB pipeline
// registers. It runs loads and stores against a 32-bit req/ack data bus.
// - A word access is a single bus beat.
// - A doubleword access (ldc1/sdc1) is two back-to-back beats: low word first,
//   then high word.
// The pipeline is stalled while a transaction is in flight. The result is
// presented to MEM/WB for exactly one cycle (DONE).
//
// Parameters
//   TIMEOUT_CYCLES     cycles req may stay high without ack before the access
//                      is aborted with a bus error (2..255)
//
// Ports
//   clk, rst           clock and synchronous active-high reset
//   EXE_MEM_*          instruction held in EXE/MEM; must stay stable while
//                      MEM_Stall=1
//   dmem_*             data-memory bus; request fields are registered and held
//                      until ack
//   MEM_Result         load result (held outside DONE)
//   MEM_R_memtoReg     one-cycle pulse, load completed
//   MEM_memWrite       one-cycle pulse, store completed
//   MEM_Stall          freeze the front of the pipeline and MEM/WB
//   MEM_Misaligned     combinational alignment-exception pulse
//   MEM_BusError       one-cycle pulse, access aborted by timeout
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EXE_MEM_MemRead,
  input  logic        EXE_MEM_MemWrite,
  input  logic        EXE_MEM_Double,
  input  logic [63:0] EXE_MEM_Result,
  input  logic [63:0] EXE_MEM_StoreData,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [63:0] MEM_Result,
  output logic        MEM_R_memtoReg,
  output logic        MEM_memWrite,
  output logic        MEM_Stall,
  output logic        MEM_Misaligned,
  output logic        MEM_BusError
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BEAT_LO = 2'd1,
    BEAT_HI = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_t      state, state_n;
  logic [7:0]  tcnt, tcnt_n;
  logic [7:0]  tcnt_inc;

  // Operation descriptor latched when leaving IDLE; EXE/MEM is not re-sampled
  // afterwards.
  logic        op_load, op_load_n;
  logic        op_double, op_double_n;
  logic [31:0] hi_addr, hi_addr_n;
  logic [31:0] hi_wdata, hi_wdata_n;
  logic [31:0] lo_data, lo_data_n;

  logic        req_n, we_n;
  logic [31:0] addr_n, wdata_n;
  logic [63:0] result_n;
  logic        memtoreg_n, memwrite_n, buserr_n;

  logic        memop;
  logic        aligned;
  logic [31:0] byte_addr;

  // Only the low 32 bits of the ALU result form the address.
  logic        unused_result_hi;
  assign unused_result_hi = ^EXE_MEM_Result[63:32];

  assign byte_addr = EXE_MEM_Result[31:0];
  assign memop     = EXE_MEM_MemRead | EXE_MEM_MemWrite;
  assign aligned   = EXE_MEM_Double ? (byte_addr[2:0] == 3'd0)
                                    : (byte_addr[1:0] == 2'd0);
  assign tcnt_inc  = tcnt + 8'd1;

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_n        = state;
    tcnt_n         = tcnt;
    op_load_n      = op_load;
    op_double_n    = op_double;
    hi_addr_n      = hi_addr;
    hi_wdata_n     = hi_wdata;
    lo_data_n      = lo_data;
    req_n          = dmem_req;
    we_n           = dmem_we;
    addr_n         = dmem_addr;
    wdata_n        = dmem_wdata;
    result_n       = MEM_Result;
    memtoreg_n     = 1'b0;
    memwrite_n     = 1'b0;
    buserr_n       = 1'b0;
    MEM_Stall      = 1'b0;
    MEM_Misaligned = 1'b0;

    unique case (state)
      IDLE: begin
        tcnt_n = 8'd0;
        if (memop) begin
          if (!aligned) begin
            // Exception is raised this cycle and the instruction moves on.
            MEM_Misaligned = 1'b1;
          end else begin
            MEM_Stall   = 1'b1;
            state_n     = BEAT_LO;
            req_n       = 1'b1;
            // Read has priority when both read and write are flagged.
            we_n        = ~EXE_MEM_MemRead;
            addr_n      = byte_addr;
            wdata_n     = EXE_MEM_StoreData[31:0];
            op_load_n   = EXE_MEM_MemRead;
            op_double_n = EXE_MEM_Double;
            hi_addr_n   = byte_addr + 32'd4;
            hi_wdata_n  = EXE_MEM_StoreData[63:32];
            lo_data_n   = 32'd0;
          end
        end
      end

      BEAT_LO, BEAT_HI: begin
        MEM_Stall = 1'b1;
        if (dmem_ack) begin
          tcnt_n = 8'd0;
          if (state == BEAT_LO && op_double) begin
            // Keep req high and retarget the bus for the high word, so the
            // second beat starts without an idle bus cycle.
            if (op_load) lo_data_n = dmem_rdata;
            state_n = BEAT_HI;
            addr_n  = hi_addr;
            wdata_n = hi_wdata;
          end else begin
            state_n = DONE;
            req_n   = 1'b0;
            if (op_load) begin
              memtoreg_n = 1'b1;
              if (state == BEAT_LO) begin
                lo_data_n = dmem_rdata;
                result_n  = {{32{dmem_rdata[31]}}, dmem_rdata};
              end else begin
                result_n  = {dmem_rdata, lo_data};
              end
            end else begin
              memwrite_n = 1'b1;
            end
          end
        end else if (tcnt_inc == TIMEOUT_LIM) begin
          tcnt_n   = tcnt_inc;
          state_n  = DONE;
          req_n    = 1'b0;
          buserr_n = 1'b1;
          result_n = 64'd0;
        end else begin
          tcnt_n = tcnt_inc;
        end
      end

      DONE: begin
        // MEM/WB captures at the closing edge of this cycle.
        state_n = IDLE;
        tcnt_n  = 8'd0;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // The pipeline is never held or trapped while in reset.
    if (rst) begin
      MEM_Stall      = 1'b0;
      MEM_Misaligned = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before the edge, independent of statement order.
    if (rst) begin
      state          <= IDLE;
      tcnt           <= 8'd0;
      op_load        <= 1'b0;
      op_double      <= 1'b0;
      hi_addr        <= 32'd0;
      hi_wdata       <= 32'd0;
      lo_data        <= 32'd0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= 32'd0;
      dmem_wdata     <= 32'd0;
      MEM_Result     <= 64'd0;
      MEM_R_memtoReg <= 1'b0;
      MEM_memWrite   <= 1'b0;
      MEM_BusError   <= 1'b0;
    end else begin
      state          <= state_n;
      tcnt           <= tcnt_n;
      op_load        <= op_load_n;
      op_double      <= op_double_n;
      hi_addr        <= hi_addr_n;
      hi_wdata       <= hi_wdata_n;
      lo_data        <= lo_data_n;
      dmem_req       <= req_n;
      dmem_we        <= we_n;
      dmem_addr      <= addr_n;
      dmem_wdata     <= wdata_n;
      MEM_Result     <= result_n;
      MEM_R_memtoReg <= memtoreg_n;
      MEM_memWrite   <= memwrite_n;
      MEM_BusError   <= buserr_n;
    end
  end

endmodule
